// File: rtl/display_mux.sv
`default_nettype none
//------------------------------------------------------------------------------
// display_mux : 4-digit multiplexed 7-segment driver (MM.SS) with
//               leading-zero blanking and sticky overflow blink.
// Revision    : 1.0
//------------------------------------------------------------------------------
module display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_SCANS = 64
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       CE,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_units,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_units,
   input  logic       OVERFLOW,
   input  logic       BLANK_LZ,
   output logic [3:0] AN,
   output logic [6:0] SEG,
   output logic       DP
);

   localparam int c_PRESC_W = $clog2(REFRESH_DIV);
   localparam int c_SCAN_W  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
   localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(REFRESH_DIV - 1);
   localparam logic [c_SCAN_W-1:0]  c_SCAN_MAX  = c_SCAN_W'(BLINK_SCANS - 1);
   localparam logic [6:0] c_SEG_OFF  = 7'b1111111;
   localparam logic [6:0] c_SEG_DASH = 7'b0111111;
   localparam logic [3:0] c_AN_OFF   = 4'b1111;

   logic [c_PRESC_W-1:0] r_presc;
   logic [1:0]           r_idx;
   logic [3:0]           r_min_tens;
   logic [3:0]           r_min_units;
   logic [3:0]           r_sec_tens;
   logic [3:0]           r_sec_units;
   logic                 r_ovf;
   logic [c_SCAN_W-1:0]  r_scan;
   logic                 r_phase;

   logic                 w_presc_wrap;
   logic                 w_capture;
   logic                 w_scan_wrap;
   logic [3:0]           w_digit;
   logic [6:0]           w_seg_dec;
   logic                 w_lz_blank;
   logic                 w_off;
   logic [3:0]           w_an;
   logic [6:0]           w_seg;
   logic                 w_dp;

   assign w_presc_wrap = (r_presc == c_PRESC_MAX);
   assign w_capture    = CE && (r_idx == 2'd0) && (r_presc == '0);
   assign w_scan_wrap  = CE && w_presc_wrap && (r_idx == 2'd3);

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
      end else if (CE) begin
         if (w_presc_wrap) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // All four digits load on one edge so a scan never mixes two timer values.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_min_tens  <= 4'd0;
         r_min_units <= 4'd0;
         r_sec_tens  <= 4'd0;
         r_sec_units <= 4'd0;
      end else if (w_capture) begin
         r_min_tens  <= min_tens;
         r_min_units <= min_units;
         r_sec_tens  <= sec_tens;
         r_sec_units <= sec_units;
      end
   end

   // Overflow is sampled every edge, independent of CE, so short pulses are never lost.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_ovf <= 1'b0;
      end else if (OVERFLOW) begin
         r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_scan  <= '0;
         r_phase <= 1'b1;
      end else if (!r_ovf) begin
         r_scan  <= '0;
         r_phase <= 1'b1;
      end else if (w_scan_wrap) begin
         if (r_scan == c_SCAN_MAX) begin
            r_scan  <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_scan  <= r_scan + 1'b1;
         end
      end
   end

   always_comb begin
      w_digit = r_sec_units;
      case (r_idx)
         2'd0: w_digit = r_sec_units;
         2'd1: w_digit = r_sec_tens;
         2'd2: w_digit = r_min_units;
         2'd3: w_digit = r_min_tens;
         default: w_digit = r_sec_units;
      endcase
   end

   always_comb begin
      w_seg_dec = c_SEG_DASH;
      case (w_digit)
         4'd0: w_seg_dec = 7'b1000000;
         4'd1: w_seg_dec = 7'b1111001;
         4'd2: w_seg_dec = 7'b0100100;
         4'd3: w_seg_dec = 7'b0110000;
         4'd4: w_seg_dec = 7'b0011001;
         4'd5: w_seg_dec = 7'b0010010;
         4'd6: w_seg_dec = 7'b0000010;
         4'd7: w_seg_dec = 7'b1111000;
         4'd8: w_seg_dec = 7'b0000000;
         4'd9: w_seg_dec = 7'b0010000;
         default: w_seg_dec = c_SEG_DASH;
      endcase
   end

   assign w_lz_blank = BLANK_LZ && (r_idx == 2'd3) && (r_min_tens == 4'd0);
   assign w_off      = !r_phase || w_lz_blank;

   always_comb begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = w_seg_dec;
      w_dp  = (r_idx != 2'd2);
      if (w_off) begin
         w_an  = c_AN_OFF;
         w_seg = c_SEG_OFF;
         w_dp  = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         AN  <= c_AN_OFF;
         SEG <= c_SEG_OFF;
         DP  <= 1'b1;
      end else if (CE) begin
         AN  <= w_an;
         SEG <= w_seg;
         DP  <= w_dp;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_display_mux.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_display_mux : directed self-checking bench for display_mux
//                  (REFRESH_DIV=4, BLINK_SCANS=2).
// Revision       : 1.0
//------------------------------------------------------------------------------
module tb_display_mux;

   logic       clk;
   logic       clr;
   logic       ce;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic       overflow;
   logic       blank_lz;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_cmp;
   int n_bad;
   int cyc;

   display_mux #(
      .REFRESH_DIV(4),
      .BLINK_SCANS(2)
   ) u_dut (
      .CLK      (clk),
      .CLR      (clr),
      .CE       (ce),
      .min_tens (min_tens),
      .min_units(min_units),
      .sec_tens (sec_tens),
      .sec_units(sec_units),
      .OVERFLOW (overflow),
      .BLANK_LZ (blank_lz),
      .AN       (an),
      .SEG      (seg),
      .DP       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each call passes n rising edges and leaves us on a falling edge.
   task automatic adv(input int n);
      repeat (n) @(negedge clk);
      cyc = cyc + n;
   endtask

   task automatic adv_to(input int target);
      if (target > cyc) adv(target - cyc);
   endtask

   task automatic do_reset(input logic [3:0] mt, input logic [3:0] mu,
                           input logic [3:0] st, input logic [3:0] su,
                           input logic blz);
      @(negedge clk);
      clr = 1'b0;
      ce = 1'b1;
      overflow = 1'b0;
      min_tens = mt; min_units = mu; sec_tens = st; sec_units = su;
      blank_lz = blz;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset;
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      clr = 1'b0;
      #1;
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_hold: AN=%b SEG=%b DP=%b want 1111 1111111 1", an, seg, dp);
      end
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      adv(10);
      clr = 1'b0;
      #1;
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_midscan: AN=%b SEG=%b DP=%b want 1111 1111111 1", an, seg, dp);
      end
   endtask

   task automatic test_scan;
      logic [3:0] exp_an  [4];
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001; exp_dp[0] = 1'b1;
      exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000; exp_dp[1] = 1'b1;
      exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100; exp_dp[2] = 1'b0;
      exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001; exp_dp[3] = 1'b1;
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      for (int k = 0; k < 5; k++) begin
         adv_to(2 + 4 * k);
         n_cmp++;
         if (an !== exp_an[k % 4] || seg !== exp_seg[k % 4] || dp !== exp_dp[k % 4]) begin
            n_bad++;
            $display("FAIL scan_slot%0d: AN=%b SEG=%b DP=%b want %b %b %b", k,
                     an, seg, dp, exp_an[k % 4], exp_seg[k % 4], exp_dp[k % 4]);
         end
      end
   endtask

   task automatic test_capture;
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      adv_to(18);
      sec_units = 4'd5;
      adv_to(20);
      n_cmp++;
      if (an !== 4'b1110 || seg !== 7'b0011001) begin
         n_bad++;
         $display("FAIL capture_hold: AN=%b SEG=%b want 1110 0011001", an, seg);
      end
      adv_to(34);
      n_cmp++;
      if (an !== 4'b1110 || seg !== 7'b0010010) begin
         n_bad++;
         $display("FAIL capture_new: AN=%b SEG=%b want 1110 0010010", an, seg);
      end
   endtask

   task automatic test_blank;
      do_reset(4'd0, 4'd2, 4'd3, 4'd4, 1'b1);
      adv_to(14);
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
         n_bad++;
         $display("FAIL lz_blank: AN=%b SEG=%b DP=%b want 1111 1111111 1", an, seg, dp);
      end
      blank_lz = 1'b0;
      adv_to(16);
      n_cmp++;
      if (an !== 4'b0111 || seg !== 7'b1000000) begin
         n_bad++;
         $display("FAIL lz_shown: AN=%b SEG=%b want 0111 1000000", an, seg);
      end
   endtask

   task automatic test_dash;
      do_reset(4'd1, 4'hF, 4'hC, 4'd4, 1'b0);
      adv_to(6);
      n_cmp++;
      if (an !== 4'b1101 || seg !== 7'b0111111) begin
         n_bad++;
         $display("FAIL dash_sec_tens: AN=%b SEG=%b want 1101 0111111", an, seg);
      end
      adv_to(10);
      n_cmp++;
      if (an !== 4'b1011 || seg !== 7'b0111111 || dp !== 1'b0) begin
         n_bad++;
         $display("FAIL dash_min_units: AN=%b SEG=%b DP=%b want 1011 0111111 0", an, seg, dp);
      end
   endtask

   task automatic test_ce_pause;
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      adv_to(6);
      ce = 1'b0;
      adv(10);
      n_cmp++;
      if (an !== 4'b1101 || seg !== 7'b0110000 || dp !== 1'b1) begin
         n_bad++;
         $display("FAIL ce_freeze: AN=%b SEG=%b DP=%b want 1101 0110000 1", an, seg, dp);
      end
      ce = 1'b1;
      adv(2);
      n_cmp++;
      if (an !== 4'b1101) begin
         n_bad++;
         $display("FAIL ce_slot_extended: AN=%b want 1101", an);
      end
      adv(1);
      n_cmp++;
      if (an !== 4'b1011 || dp !== 1'b0) begin
         n_bad++;
         $display("FAIL ce_resume: AN=%b DP=%b want 1011 0", an, dp);
      end
   endtask

   task automatic test_overflow;
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      adv_to(2);
      overflow = 1'b1;
      adv(1);
      overflow = 1'b0;
      n_cmp++;
      if (an !== 4'b1110 || seg !== 7'b0011001) begin
         n_bad++;
         $display("FAIL ovf_starts_on: AN=%b SEG=%b want 1110 0011001", an, seg);
      end
      adv_to(32);
      n_cmp++;
      if (an !== 4'b0111) begin
         n_bad++;
         $display("FAIL ovf_last_on: AN=%b want 0111", an);
      end
      adv_to(33);
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_off: AN=%b SEG=%b DP=%b want 1111 1111111 1", an, seg, dp);
      end
      adv_to(48);
      n_cmp++;
      if (an !== 4'b1111 || dp !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_off_dp: AN=%b DP=%b want 1111 1", an, dp);
      end
      adv_to(64);
      n_cmp++;
      if (an !== 4'b1111) begin
         n_bad++;
         $display("FAIL ovf_last_off: AN=%b want 1111", an);
      end
      adv_to(65);
      n_cmp++;
      if (an !== 4'b1110 || seg !== 7'b0011001) begin
         n_bad++;
         $display("FAIL ovf_back_on: AN=%b SEG=%b want 1110 0011001", an, seg);
      end
      adv_to(97);
      n_cmp++;
      if (an !== 4'b1111) begin
         n_bad++;
         $display("FAIL ovf_off_again: AN=%b want 1111", an);
      end
      adv_to(100);
      clr = 1'b0;
      #1;
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_reset: AN=%b SEG=%b DP=%b want 1111 1111111 1", an, seg, dp);
      end
      @(negedge clk);
      clr = 1'b1;
      cyc = 0;
      adv_to(33);
      n_cmp++;
      if (an !== 4'b1110 || seg !== 7'b0011001) begin
         n_bad++;
         $display("FAIL ovf_latch_cleared: AN=%b SEG=%b want 1110 0011001", an, seg);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cyc = 0;
      clr = 1'b0;
      ce = 1'b0;
      overflow = 1'b0;
      blank_lz = 1'b0;
      min_tens = 4'd0; min_units = 4'd0; sec_tens = 4'd0; sec_units = 4'd0;
      test_reset;
      test_scan;
      test_capture;
      test_blank;
      test_dash;
      test_ce_pause;
      test_overflow;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
